adc_sample_framer: RTL
======================

# adc_sample_framer

Decimates the raw 12-bit sample stream from `AdcInterface` and packs the surviving samples into checksummed byte frames for `UartTx`. It replaces the fixed "send low byte of every Nth sample" path in the ADC bring-up top. The replacement adds power-of-two decimation with pick or average mode, full-width samples, error-sample rejection and framing. A small sample FIFO with overflow accounting decouples decimation from the byte-level backpressure handshake.

## Interface
Parameters:
- `DATA_W`, 12, sample width, 1..16.
- `DECIM_LOG2`, 11, window = 2**DECIM_LOG2 good samples; 0 passes every sample.
- `MODE`, 0, 0 = keep last sample of window, 1 = window average (truncated).
- `FRAME_LEN`, 8, samples per frame, 1..255.
- `FIFO_ABITS`, 2, sample FIFO depth = 2**FIFO_ABITS.
- `SYNC_BYTE`, 8'hA5, frame header.

Ports:
- `clk`  in  1  single clock (the ADC `sck` domain).
- `rst`  in  1  reset, asynchronous, active-high.
- `sample_i`  in  DATA_W  ADC sample.
- `sample_valid_i`  in  1  one-cycle strobe, sample_i valid.
- `sample_error_i`  in  1  qualifies sample_valid_i; sample is bad.
- `byte_o`  out  8  frame byte.
- `byte_valid_o`  out  1  byte_o valid.
- `byte_ready_i`  in  1  sink accepts (UartTx not full).
- `clr_i`  in  1  clears sticky flags and counters.
- `overflow_o`  out  1  sticky: decimated sample dropped, FIFO full.
- `err_count_o`  out  8  saturating count of bad samples.

## Operation
- Decimator: good samples (valid && !error) advance window counter `win` (DECIM_LOG2 bits). Bad samples are ignored by the window and increment err_count_o, which saturates at 255.
- MODE 0: on the good sample with `win` = all-ones, push that sample. MODE 1: accumulator (DATA_W+DECIM_LOG2 bits) sums the window. On the last sample, push (acc + sample) >> DECIM_LOG2, and the accumulator reloads to 0.
- Push into a full FIFO: sample dropped, overflow_o set. The window continues normally.
- Serializer FSM: IDLE -> SYNC -> SEQ -> HI -> LO -> (HI while samples remain in frame, else CSUM) -> IDLE.
- IDLE leaves when FIFO non-empty. HI with FIFO empty holds byte_valid_o low (stall), no timeout.
- Bytes, in order:
  - SYNC_BYTE.
  - seq: 8-bit, +1 per frame, wraps 255->0, first frame 0.
  - Per sample: HI = zero-extended sample[15:8], then LO = sample[7:0].
  - CSUM = XOR of seq and all HI/LO bytes.
- FIFO pops on acceptance of the LO byte.
- clr_i: overflow_o <= 0, err_count_o <= 0. clr_i coincident with a set event: the set event wins.

## Timing
- Reset values: byte_o 0, byte_valid_o 0, overflow_o 0, err_count_o 0, FSM IDLE, seq 0, win 0, acc 0, FIFO empty.
- Push: the FIFO holds the decimated sample 1 cycle after the window-closing sample_valid_i.
- First-sample latency: FIFO non-empty to SYNC byte_valid_o = 1 cycle (registered outputs).
- Handshake: a transfer occurs when byte_valid_o && byte_ready_i. While valid && !ready, byte_o and byte_valid_o hold stable. Back-to-back bytes are allowed with ready held high, 1 byte/cycle.
- Simultaneous push and pop on a full FIFO: the push succeeds, no overflow.
- Reset mid-frame: the frame is abandoned, the next frame restarts at SYNC with seq 0.

## Structure
- Package `adc_frame_pkg`: serializer state enum (IDLE, SYNC, SEQ, HI, LO, CSUM), default SYNC_BYTE, byte-layout constants.
- Sub-module `SampleFifo` (synchronous FWFT, parametrised width/depth, full/empty). Decimator and FSM live in the top of the block.

## Test plan
- MODE 0, DECIM_LOG2=2, FRAME_LEN=2, samples 0..7 with ready high -> bytes A5,00,00,03,00,07,04.
- MODE 1, DECIM_LOG2=2, samples 0xFFF,0xFFF,0xFFF,0xFFC -> pushed 0xFFE, then bytes 0F,FE.
- Same as first, byte_ready_i toggling 1-of-3 cycles -> identical byte sequence, byte_o stable while stalled.
- FIFO_ABITS=1, ready low, 3 decimated samples -> overflow_o=1, first 2 samples later emitted. clr_i -> overflow_o=0.
- Error samples interleaved (every 2nd sample errored, DECIM_LOG2=1) -> window counts good only, err_count_o matches the bad count, saturates at 255 after 300 errors.
- rst asserted during LO byte -> all outputs to reset values at once. The next frame starts A5,00.

Source files
------------

// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC sample framer.
package adc_frame_pkg;

  // Serializer states, in the order bytes leave the block.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    SEQ  = 3'd2,
    HI   = 3'd3,
    LO   = 3'd4,
    CSUM = 3'd5
  } ser_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Every sample travels as a 16-bit big-endian pair, zero-extended.
  localparam int SAMPLE_FRAME_W = 16;

  function automatic logic [7:0] sample_hi(input logic [SAMPLE_FRAME_W-1:0] s);
    return s[15:8];
  endfunction

  function automatic logic [7:0] sample_lo(input logic [SAMPLE_FRAME_W-1:0] s);
    return s[7:0];
  endfunction

endpackage

// File: rtl/SampleFifo.sv
// First-word-fall-through sample FIFO; a pop frees a slot for a same-cycle push.
module SampleFifo #(
  parameter int WIDTH = 12,
  parameter int ABITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS:0] FULL_COUNT = {1'b1, {ABITS{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;
  logic [ABITS:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_sample_framer.sv
// Decimates ADC samples and serializes them into SYNC/seq/samples/XOR-checksum frames.
// Byte handshake: a byte moves when byte_valid_o && byte_ready_i at a rising edge;
// while valid is high and ready low, byte_o and byte_valid_o do not change.
module adc_sample_framer
  import adc_frame_pkg::*;
#(
  parameter int         DATA_W     = 12,
  parameter int         DECIM_LOG2 = 11,
  parameter int         MODE       = 0,
  parameter int         FRAME_LEN  = 8,
  parameter int         FIFO_ABITS = 2,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              sample_error_i,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  input  logic              clr_i,
  output logic              overflow_o,
  output logic [7:0]        err_count_o,
  output logic [2:0]        state_o
);

  localparam int WIN_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int ACC_W = DATA_W + DECIM_LOG2;

  // ---------------- decimator ----------------
  logic [WIN_W-1:0]  win;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic              good;
  logic              bad;
  logic              win_last;
  logic              push_req;
  logic [DATA_W-1:0] push_data;

  assign good      = sample_valid_i && !sample_error_i;
  assign bad       = sample_valid_i && sample_error_i;
  assign win_last  = (DECIM_LOG2 == 0) || (win == {WIN_W{1'b1}});
  assign acc_sum   = acc + ACC_W'(sample_i);
  assign push_req  = good && win_last;
  assign push_data = (MODE == 1) ? DATA_W'(acc_sum >> DECIM_LOG2) : sample_i;

  // Window position and running sum advance on good samples only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win <= '0;
      acc <= '0;
    end else if (good) begin
      win <= win_last ? '0 : win + 1'b1;
      acc <= win_last ? '0 : acc_sum;
    end
  end

  // ---------------- sample FIFO ----------------
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;

  SampleFifo #(.WIDTH(DATA_W), .ABITS(FIFO_ABITS)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (push_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A pop in the same cycle makes room, so only a full, non-popping FIFO drops.
  assign drop = push_req && fifo_full && !fifo_pop;

  // Sticky flags; a set event outranks a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_o  <= 1'b0;
      err_count_o <= 8'h00;
    end else begin
      if (drop)       overflow_o <= 1'b1;
      else if (clr_i) overflow_o <= 1'b0;
      if (bad) begin
        if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'h01;
      end else if (clr_i) begin
        err_count_o <= 8'h00;
      end
    end
  end

  // ---------------- serializer ----------------
  ser_state_t  state;
  ser_state_t  state_n;
  logic [7:0]  byte_n;
  logic        valid_n;
  logic [7:0]  seq;
  logic [7:0]  csum;
  logic [7:0]  cnt;
  logic        xfer;
  logic        last_sample;
  logic [15:0] head16;

  assign xfer        = byte_valid_o && byte_ready_i;
  assign last_sample = (cnt == 8'(FRAME_LEN - 1));
  assign head16      = 16'(fifo_dout);
  assign state_o     = state;

  // Next state and next registered byte/valid; defaults hold the current byte.
  always_comb begin
    state_n  = state;
    byte_n   = byte_o;
    valid_n  = byte_valid_o;
    fifo_pop = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        state_n = SYNC;
        byte_n  = SYNC_BYTE;
        valid_n = 1'b1;
      end
      SYNC: if (xfer) begin
        state_n = SEQ;
        byte_n  = seq;
      end
      // Nothing pops before the first LO, so the head is present here.
      SEQ: if (xfer) begin
        state_n = HI;
        byte_n  = sample_hi(head16);
      end
      HI: begin
        if (xfer) begin
          state_n = LO;
          byte_n  = sample_lo(head16);
        end else if (!byte_valid_o && !fifo_empty) begin
          byte_n  = sample_hi(head16);
          valid_n = 1'b1;
        end
      end
      LO: if (xfer) begin
        fifo_pop = 1'b1;
        if (last_sample) begin
          state_n = CSUM;
          byte_n  = csum ^ byte_o;
        end else begin
          state_n = HI;
          valid_n = 1'b0;
        end
      end
      CSUM: if (xfer) begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  // State, output registers, frame counter, sequence number and running checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_o       <= 8'h00;
      byte_valid_o <= 1'b0;
      seq          <= 8'h00;
      csum         <= 8'h00;
      cnt          <= 8'h00;
    end else begin
      state        <= state_n;
      byte_o       <= byte_n;
      byte_valid_o <= valid_n;
      if (xfer) begin
        case (state)
          SYNC:    begin csum <= seq; cnt <= 8'h00; end
          HI:      csum <= csum ^ byte_o;
          LO:      begin csum <= csum ^ byte_o; cnt <= cnt + 8'h01; end
          CSUM:    seq <= seq + 8'h01;
          default: ;
        endcase
      end
    end
  end

endmodule
